// File: rtl/wb_select_skid.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_skid
//  Description : Writeback result selector for the RV32I core. Picks one of
//                NUM_IN source buses, qualifies the register-file write
//                enable, and registers the result behind a 2-entry skid
//                buffer so in_ready never depends combinationally on
//                out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_select_skid #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic                    in_we,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [ADDR_W-1:0]       out_rd,
    output logic                    out_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    localparam logic [ADDR_W-1:0] c_rd_x0   = '0;
    localparam logic [7:0]        c_cnt_max = 8'hFF;

    // Buffer state: main holds the presented entry, skid the overflow entry.
    logic              r_main_v;
    logic [WIDTH-1:0]  r_main_data;
    logic [ADDR_W-1:0] r_main_rd;
    logic              r_main_we;
    logic              r_skid_v;
    logic [WIDTH-1:0]  r_skid_data;
    logic [ADDR_W-1:0] r_skid_rd;
    logic              r_skid_we;

    logic              r_sel_err;
    logic [7:0]        r_err_cnt;

    logic [WIDTH-1:0]  w_sel_data;
    logic              w_in_range;
    logic              w_we_q;
    logic              w_accept;
    logic              w_xfer;

    // Source mux; an out-of-range select yields zero data and no match.
    always_comb begin
        w_sel_data = '0;
        w_in_range = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
                w_in_range = 1'b1;
            end
        end
    end

    // x0 is never written and a bad select never writes.
    assign w_we_q   = in_we & w_in_range & (in_rd != c_rd_x0);

    // A flushed cycle discards its accept entirely, including error counting.
    assign w_accept = in_valid & ~r_skid_v & ~flush;
    assign w_xfer   = r_main_v & out_ready;

    // Skid buffer: EMPTY -> ONE -> FULL and back, flush returns to EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v    <= 1'b0;
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_we   <= 1'b0;
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_we   <= 1'b0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            if (out_ready) begin
                r_main_data <= r_skid_data;
                r_main_rd   <= r_skid_rd;
                r_main_we   <= r_skid_we;
                r_skid_v    <= 1'b0;
            end
        end else if (r_main_v) begin
            if (w_accept && !w_xfer) begin
                r_skid_data <= w_sel_data;
                r_skid_rd   <= in_rd;
                r_skid_we   <= w_we_q;
                r_skid_v    <= 1'b1;
            end else if (w_accept && w_xfer) begin
                r_main_data <= w_sel_data;
                r_main_rd   <= in_rd;
                r_main_we   <= w_we_q;
            end else if (w_xfer) begin
                r_main_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_main_data <= w_sel_data;
            r_main_rd   <= in_rd;
            r_main_we   <= w_we_q;
            r_main_v    <= 1'b1;
        end
    end

    // Sticky select-error flag and saturating counter; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_accept && !w_in_range) begin
            r_sel_err <= 1'b1;
            if (r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = ~r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_data;
    assign out_rd    = r_main_rd;
    assign out_we    = r_main_we;
    assign sel_err   = r_sel_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_select_skid
//  Description : Self-checking bench for wb_select_skid (NUM_IN=3) with a
//                queue-based reference model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_skid;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int ADDR_W = 5;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic [ADDR_W-1:0]       in_rd;
    logic                    in_we;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [ADDR_W-1:0]       out_rd;
    logic                    out_we;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [7:0]              err_cnt;

    wb_select_skid #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_rd    (in_rd),
        .in_we    (in_we),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_rd   (out_rd),
        .out_we   (out_we),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } entry_t;

    entry_t m_q[$];
    int     m_err_cnt;
    bit     m_sel_err;
    int     n_acc;
    int     n_cmp;
    int     n_bad;
    bit     chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a bounded FIFO of depth 2 with flush and error counting.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_err_cnt = 0;
            m_sel_err = 1'b0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            bit     acc;
            bit     xfr;
            entry_t e;
            acc = in_valid && (m_q.size() < 2);
            xfr = (m_q.size() > 0) && out_ready;
            if (xfr) void'(m_q.pop_front());
            if (acc) begin
                if (int'(in_sel) < NUM_IN) begin
                    e.data = in_data[int'(in_sel)*WIDTH +: WIDTH];
                    e.we   = in_we && (in_rd != 0);
                end else begin
                    e.data = '0;
                    e.we   = 1'b0;
                    m_sel_err = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
                e.rd = in_rd;
                m_q.push_back(e);
                n_acc++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            check("sel_err", 32'(sel_err), 32'(m_sel_err));
            check("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
            if (m_q.size() > 0) begin
                check("out_data", out_data, m_q[0].data);
                check("out_rd", 32'(out_rd), 32'(m_q[0].rd));
                check("out_we", 32'(out_we), 32'(m_q[0].we));
            end
        end
    end

    task automatic put(input bit v, input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] r, input bit w);
        in_valid = v;
        in_sel   = s;
        in_rd    = r;
        in_we    = w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst = 1'b1; flush = 1'b0; in_data = '0; out_ready = 1'b0;
        put(1'b0, 2'd0, 5'd0, 1'b0);
        chk_en = 1'b0;
        n_acc = 0; n_cmp = 0; n_bad = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_data", out_data, 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);

        // Single entry, latency 1
        in_data = {32'h0000_0004, 32'hDEAD_BEEF, 32'h1234_5678};
        out_ready = 1'b1;
        put(1'b1, 2'd1, 5'd5, 1'b1);
        @(negedge clk);
        put(1'b0, 2'd0, 5'd0, 1'b0);
        check("single out_valid", 32'(out_valid), 32'd1);
        check("single out_data", out_data, 32'hDEAD_BEEF);
        check("single out_rd", 32'(out_rd), 32'd5);
        check("single out_we", 32'(out_we), 32'd1);
        @(negedge clk);
        check("single drop", 32'(out_valid), 32'd0);

        // Backpressure fill, ordered drain
        out_ready = 1'b0;
        put(1'b1, 2'd0, 5'd1, 1'b1);
        @(negedge clk);
        put(1'b1, 2'd1, 5'd2, 1'b1);
        @(negedge clk);
        put(1'b1, 2'd2, 5'd3, 1'b1);
        check("bp in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp held head", out_data, 32'h1234_5678);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp second", out_data, 32'hDEAD_BEEF);
        @(negedge clk);
        put(1'b0, 2'd0, 5'd0, 1'b0);
        check("bp third", out_data, 32'h0000_0004);
        check("bp in_ready back", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Out-of-range select
        put(1'b1, 2'd3, 5'd7, 1'b1);
        @(negedge clk);
        put(1'b1, 2'd0, 5'd8, 1'b1);
        check("oor out_data", out_data, 32'd0);
        check("oor out_we", 32'(out_we), 32'd0);
        check("oor sel_err", 32'(sel_err), 32'd1);
        check("oor err_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk);
        check("oor sticky", 32'(sel_err), 32'd1);

        // x0 suppression
        put(1'b1, 2'd0, 5'd0, 1'b1);
        @(negedge clk);
        put(1'b0, 2'd0, 5'd0, 1'b0);
        check("x0 out_we", 32'(out_we), 32'd0);
        check("x0 out_data", out_data, 32'h1234_5678);
        @(negedge clk);

        // Flush while FULL with simultaneous in_valid
        out_ready = 1'b0;
        put(1'b1, 2'd3, 5'd9, 1'b1);
        @(negedge clk);
        put(1'b1, 2'd2, 5'd10, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        put(1'b1, 2'd1, 5'd11, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        put(1'b0, 2'd0, 5'd0, 1'b0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush err_cnt", 32'(err_cnt), 32'd2);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        put(1'b1, 2'd1, 5'd12, 1'b1);
        @(negedge clk);
        put(1'b1, 2'd2, 5'd13, 1'b1);
        @(negedge clk);
        put(1'b0, 2'd0, 5'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst in_ready", 32'(in_ready), 32'd1);
        check("arst err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomised streaming
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            in_data   = {$urandom, $urandom, $urandom};
            put(($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, 3)),
                ADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (n_acc < 1000) begin
            n_bad++;
            $display("FAIL stream budget: got %0d accepts, expected 1000", n_acc);
        end
        flush = 1'b0;
        put(1'b0, 2'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_select_skid.md
Name: wb_select_skid

Overview:
- Parametrised writeback result selector for the RV32I core.
- Selects one of NUM_IN source buses (ALU result, load data, PC+4, immediate, ...), qualifies the register-file write, and registers the result behind a 2-entry skid buffer.
- Sits between the MEM/WB boundary and the register-file write port, so writeback can stall on out_ready without a combinational ready path back into the pipeline.

Parameters:
- WIDTH, 32, data width of every source and of the result
- NUM_IN, 4, number of selectable sources (2..16)
- SEL_W, 2, width of the select field; must satisfy 2**SEL_W >= NUM_IN
- ADDR_W, 5, destination register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous discard of all buffered entries
- in_data  in  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  source index
- in_rd  in  ADDR_W  destination register
- in_we  in  1  register write request
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept; registered, no combinational path from out_ready
- out_data  out  WIDTH  selected result
- out_rd  out  ADDR_W  destination register
- out_we  out  1  qualified write enable
- out_valid  out  1  output entry valid
- out_ready  in  1  register file / downstream accepts
- sel_err  out  1  sticky flag: an accepted entry had in_sel >= NUM_IN
- err_cnt  out  8  saturating count of accepted out-of-range selects

Behaviour:
- Reset (asynchronous, any time) clears all state:
  - out_valid=0, out_data=0, out_rd=0, out_we=0, in_ready=1, sel_err=0, err_cnt=0.
  - Buffer state returns to EMPTY.
  - Reset mid-transfer drops both entries.
- Accept: in_valid & in_ready at a rising edge.
- Output transfer: out_valid & out_ready at a rising edge.
- Selection and qualification, applied at accept time:
  - in_sel < NUM_IN: data = source in_sel.
  - in_sel >= NUM_IN: data = 0, we forced 0, sel_err set, err_cnt incremented (saturates at 255).
  - in_rd == 0: we forced 0 (x0 is never written); data is passed through unchanged.
- Buffer states are encoded in main_v and skid_v:
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> ONE (main loaded). out_valid rises the cycle after accept (latency 1).
  - ONE: out_valid=1, in_ready=1.
    - Accept without transfer -> FULL (skid loaded).
    - Transfer without accept -> EMPTY.
    - Accept and transfer together -> ONE, with main reloaded from the input.
  - FULL: out_valid=1, in_ready=0.
    - Transfer -> ONE, with main loaded from skid. No accept is possible in FULL.
- Ordering: entries leave strictly in accept order, with no loss or duplication.
- out_* hold stable while out_valid=1 and out_ready=0.
- flush:
  - Takes priority over accept and transfer in the same cycle; the next state is EMPTY and any accept that cycle is discarded.
  - sel_err and err_cnt are not cleared by flush.
  - in_ready is 1 the cycle after flush.
- sel_err and err_cnt are cleared only by rst.
- Throughput: 1 entry per cycle while out_ready=1.

Test Plan:
- Reset then single entry: rst pulse; in_data = {0,0x0000_0004,0xDEAD_BEEF,0x1234_5678}, in_sel=1, in_rd=5, in_we=1, in_valid for 1 cycle, out_ready=1 -> out_valid=1 next cycle with out_data=0xDEAD_BEEF, out_rd=5, out_we=1; out_valid drops the following cycle.
- Backpressure fill: out_ready=0, three consecutive entries with in_sel=0,1,2 -> in_ready=0 after the 2nd accept, 3rd held upstream; raise out_ready -> outputs appear in order sel0, sel1, sel2 data with no gaps or duplicates, in_ready returns to 1.
- Out-of-range select with NUM_IN=3: accepted entry with in_sel=3, in_we=1 -> out_data=0, out_we=0, sel_err=1, err_cnt=1; a following valid entry leaves sel_err=1.
- x0 suppression: in_rd=0, in_we=1, in_sel=0 -> out_we=0, out_data = source 0.
- Flush while FULL with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, discarded entries never appear; err_cnt unchanged.
- Async reset mid-stream: assert rst between edges while FULL -> out_valid=0, in_ready=1, err_cnt=0 immediately, without waiting for a clock edge. Randomised valid/ready streaming for 1000 entries against a scoreboard -> exact in-order match.
